pong_ball_ctrl: RTL and testbench

Ball motion engine for the Pong datapath. It consumes the one-cycle terminal-count pulse from the game-rate timer and advances the ball one pixel per axis per tick. It bounces the ball off the top and bottom walls and the two paddles, and detects misses. It reports the ball position to the renderer, and reports score and hit events to the score and sound logic.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_serve_counter.sv | 35 +++
 rtl/pong_ball_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the Pong ball engine.
// Field geometry is in pixels; the centre position is where the ball
// sits in IDLE and where it is placed again after every point.
package pong_pkg;

  localparam int FIELD_W    = 160;
  localparam int FIELD_H    = 120;
  localparam int BALL_SZ    = 4;
  localparam int PAD_H      = 16;
  localparam int PAD_L_FACE = 8;
  localparam int PAD_R_FACE = 152;

  localparam int CX = (FIELD_W - BALL_SZ) / 2;
  localparam int CY = (FIELD_H - BALL_SZ) / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    MOVE  = 2'b10
  } state_t;

endpackage

// File: rtl/pong_serve_counter.sv
// Serve hold-off counter: counts game ticks while the ball waits at centre.
// Ports:
//   Clk  - system clock
//   Rst  - synchronous active-low reset
//   Clr  - synchronous clear (wins over Tick)
//   Tick - count enable, one-cycle game-rate pulse
//   Done - combinational: the tick that completes the hold-off
module pong_serve_counter #(
  parameter int SERVE_TICKS = 30
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  input  logic Tick,
  output logic Done
);

  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_TICKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count <= '0;
    end else if (Clr) begin
      count <= '0;
    end else if (Tick) begin
      count <= count + CNT_W'(1);
    end
  end

  assign Done = Tick && (count == LAST);

endmodule

// File: rtl/pong_ball_ctrl.sv
// Ball motion engine. On every game tick in MOVE the ball advances one pixel
// per axis, reflecting off the top/bottom walls and the paddle faces; a ball
// that reaches either side edge scores for the opposite player and is served
// again from the centre after a hold-off.
// Ports:
//   Clk     - system clock
//   Rst     - synchronous active-low reset
//   Tick    - one-cycle game-rate pulse
//   Start   - level, leaves IDLE
//   PadL_Y  - top row of left paddle
//   PadR_Y  - top row of right paddle
//   BallX   - ball left column (registered)
//   BallY   - ball top row (registered)
//   Hit     - one-cycle pulse on a paddle bounce
//   ScoreL  - one-cycle pulse, ball left the field on the right
//   ScoreR  - one-cycle pulse, ball left the field on the left
//   Playing - high while serving or moving
module pong_ball_ctrl #(
  parameter int FIELD_W     = pong_pkg::FIELD_W,
  parameter int FIELD_H     = pong_pkg::FIELD_H,
  parameter int BALL_SZ     = pong_pkg::BALL_SZ,
  parameter int PAD_H       = pong_pkg::PAD_H,
  parameter int PAD_L_FACE  = pong_pkg::PAD_L_FACE,
  parameter int PAD_R_FACE  = pong_pkg::PAD_R_FACE,
  parameter int SERVE_TICKS = 30
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Start,
  input  logic [6:0] PadL_Y,
  input  logic [6:0] PadR_Y,
  output logic [7:0] BallX,
  output logic [6:0] BallY,
  output logic       Hit,
  output logic       ScoreL,
  output logic       ScoreR,
  output logic       Playing
);

  import pong_pkg::*;

  localparam logic [7:0] X_MAX   = 8'(FIELD_W - BALL_SZ);
  localparam logic [6:0] Y_MAX   = 7'(FIELD_H - BALL_SZ);
  localparam logic [7:0] X_CTR   = 8'((FIELD_W - BALL_SZ) / 2);
  localparam logic [6:0] Y_CTR   = 7'((FIELD_H - BALL_SZ) / 2);
  localparam logic [7:0] L_FACE  = 8'(PAD_L_FACE);
  localparam logic [8:0] R_FACE  = 9'(PAD_R_FACE);
  localparam logic [8:0] BALL_X9 = 9'(BALL_SZ);
  localparam logic [7:0] BALL_Y8 = 8'(BALL_SZ);
  localparam logic [7:0] PAD_H8  = 8'(PAD_H);

  // Vertical overlap of ball and paddle, widened to 8 bits so that
  // row+height near the bottom of the 7-bit range cannot wrap.
  function automatic logic overlap(input logic [6:0] ball_top,
                                   input logic [6:0] pad_top);
    logic [7:0] b;
    logic [7:0] p;
    b = {1'b0, ball_top};
    p = {1'b0, pad_top};
    return ((b + BALL_Y8) > p) && (b < (p + PAD_H8));
  endfunction

  state_t     state, state_nx;
  logic       dx, dx_nx;
  logic       dy, dy_nx;
  logic [7:0] ball_x_nx;
  logic [6:0] ball_y_nx;
  logic       hit_nx, score_l_nx, score_r_nx, playing_nx;

  logic [6:0] y_step;
  logic       dy_step;
  logic [8:0] x_end;
  logic       bounce_l, bounce_r, miss_l, miss_r;
  logic       scored, cnt_clr, cnt_tick, serve_done;

  // Vertical move for this tick, including the wall reflection.
  always_comb begin
    y_step  = BallY;
    dy_step = dy;
    if (!dy && (BallY == 7'd0)) begin
      y_step  = 7'd1;
      dy_step = 1'b1;
    end else if (dy && (BallY == Y_MAX)) begin
      y_step  = BallY - 7'd1;
      dy_step = 1'b0;
    end else if (dy) begin
      y_step  = BallY + 7'd1;
    end else begin
      y_step  = BallY - 7'd1;
    end
  end

  assign x_end    = {1'b0, BallX} + BALL_X9;
  assign bounce_l = !dx && (BallX == L_FACE) && overlap(BallY, PadL_Y);
  assign bounce_r = dx && (x_end == R_FACE) && overlap(BallY, PadR_Y);
  assign miss_l   = !dx && (BallX == 8'd0);
  assign miss_r   = dx && (BallX == X_MAX);

  // Paddle bounces take priority over an edge miss on the same tick.
  assign scored   = (state == MOVE) && Tick && !bounce_l && !bounce_r &&
                    (miss_l || miss_r);
  assign cnt_clr  = ((state == IDLE) && Start) || scored;
  assign cnt_tick = (state == SERVE) && Tick;

  pong_serve_counter #(
    .SERVE_TICKS(SERVE_TICKS)
  ) u_serve_counter (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (cnt_clr),
    .Tick(cnt_tick),
    .Done(serve_done)
  );

  always_comb begin
    state_nx   = state;
    ball_x_nx  = BallX;
    ball_y_nx  = BallY;
    dx_nx      = dx;
    dy_nx      = dy;
    hit_nx     = 1'b0;
    score_l_nx = 1'b0;
    score_r_nx = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nx = SERVE;
      end
      SERVE: begin
        if (serve_done) state_nx = MOVE;
      end
      MOVE: begin
        if (Tick) begin
          ball_y_nx = y_step;
          dy_nx     = dy_step;
          if (bounce_l) begin
            dx_nx     = 1'b1;
            ball_x_nx = BallX + 8'd1;
            hit_nx    = 1'b1;
          end else if (bounce_r) begin
            dx_nx     = 1'b0;
            ball_x_nx = BallX - 8'd1;
            hit_nx    = 1'b1;
          end else if (miss_l || miss_r) begin
            // Recentre and serve toward the player who lost the point;
            // the vertical step of this tick is dropped, DY is kept.
            score_r_nx = miss_l;
            score_l_nx = miss_r;
            dx_nx      = miss_r;
            ball_x_nx  = X_CTR;
            ball_y_nx  = Y_CTR;
            dy_nx      = dy;
            state_nx   = SERVE;
          end else if (dx) begin
            ball_x_nx = BallX + 8'd1;
          end else begin
            ball_x_nx = BallX - 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    playing_nx = (state_nx != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= IDLE;
      BallX   <= X_CTR;
      BallY   <= Y_CTR;
      dx      <= 1'b1;
      dy      <= 1'b1;
      Hit     <= 1'b0;
      ScoreL  <= 1'b0;
      ScoreR  <= 1'b0;
      Playing <= 1'b0;
    end else begin
      state   <= state_nx;
      BallX   <= ball_x_nx;
      BallY   <= ball_y_nx;
      dx      <= dx_nx;
      dy      <= dy_nx;
      Hit     <= hit_nx;
      ScoreL  <= score_l_nx;
      ScoreR  <= score_r_nx;
      Playing <= playing_nx;
    end
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: a vector table for the opening rally, hand-written
// sequences for paddle hits, scoring and reset, then randomized play checked
// every cycle against a velocity-based reference model.
module tb_pong_ball_ctrl;

  localparam int FW = 160;
  localparam int FH = 120;
  localparam int BS = 4;
  localparam int PH = 16;
  localparam int PLF = 8;
  localparam int PRF = 152;
  localparam int SERVE_TICKS = 30;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [6:0] pad_l_y = 7'd0;
  logic [6:0] pad_r_y = 7'd0;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       hit, score_l, score_r, playing;

  int tests = 0;
  int fails = 0;

  pong_ball_ctrl dut (
    .Clk    (clk),
    .Rst    (rst),
    .Tick   (tick),
    .Start  (start),
    .PadL_Y (pad_l_y),
    .PadR_Y (pad_r_y),
    .BallX  (ball_x),
    .BallY  (ball_y),
    .Hit    (hit),
    .ScoreL (score_l),
    .ScoreR (score_r),
    .Playing(playing)
  );

  always #5 clk = ~clk;

  // Reference model: position plus signed velocity, serve as a countdown.
  int m_x = 78, m_y = 58, m_vx = 1, m_vy = 1, m_phase = PH_IDLE, m_wait = 0;
  int m_hit = 0, m_sl = 0, m_sr = 0, m_play = 0;

  task automatic serve_from_centre(input int vx);
    m_x     = (FW - BS) / 2;
    m_y     = (FH - BS) / 2;
    m_vx    = vx;
    m_phase = PH_SERVE;
    m_wait  = SERVE_TICKS;
  endtask

  task automatic model_step();
    int nvy, ny, pl, pr;
    bit ovl_l, ovl_r;
    m_hit = 0; m_sl = 0; m_sr = 0;
    if (!rst) begin
      m_phase = PH_IDLE; m_x = 78; m_y = 58; m_vx = 1; m_vy = 1; m_wait = 0;
    end else if (m_phase == PH_IDLE) begin
      if (start) begin m_phase = PH_SERVE; m_wait = SERVE_TICKS; end
    end else if (m_phase == PH_SERVE) begin
      if (tick) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) m_phase = PH_PLAY;
      end
    end else if (tick) begin
      nvy = m_vy;
      if ((m_y == 0 && m_vy < 0) || (m_y == FH - BS && m_vy > 0)) nvy = -m_vy;
      ny = m_y + nvy;
      pl = int'(pad_l_y);
      pr = int'(pad_r_y);
      ovl_l = (m_y + BS > pl) && (m_y < pl + PH);
      ovl_r = (m_y + BS > pr) && (m_y < pr + PH);
      if (m_vx < 0 && m_x == PLF && ovl_l) begin
        m_vx = 1; m_x = m_x + m_vx; m_hit = 1;
      end else if (m_vx > 0 && m_x + BS == PRF && ovl_r) begin
        m_vx = -1; m_x = m_x + m_vx; m_hit = 1;
      end else if (m_vx < 0 && m_x == 0) begin
        m_sr = 1; serve_from_centre(-1);
      end else if (m_vx > 0 && m_x == FW - BS) begin
        m_sl = 1; serve_from_centre(1);
      end else begin
        m_x = m_x + m_vx;
      end
      if (m_sl == 0 && m_sr == 0) begin m_y = ny; m_vy = nvy; end
    end
    m_play = (m_phase != PH_IDLE) ? 1 : 0;
  endtask

  task automatic check_model();
    tests++;
    if (ball_x !== 8'(m_x) || ball_y !== 7'(m_y) || hit !== 1'(m_hit) ||
        score_l !== 1'(m_sl) || score_r !== 1'(m_sr) || playing !== 1'(m_play)) begin
      fails++;
      $display("FAIL model t=%0t got x=%0d y=%0d hit=%b sl=%b sr=%b play=%b want x=%0d y=%0d hit=%0d sl=%0d sr=%0d play=%0d",
               $time, ball_x, ball_y, hit, score_l, score_r, playing,
               m_x, m_y, m_hit, m_sl, m_sr, m_play);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic run(input int n, input int r, input int t, input int s,
                     input int pl, input int pr);
    rst = 1'(r); tick = 1'(t); start = 1'(s);
    pad_l_y = 7'(pl); pad_r_y = 7'(pr);
    repeat (n) cycle();
  endtask

  task automatic expect_out(input string name, input int ex, input int ey,
                            input int eh, input int esl, input int esr, input int ep);
    tests++;
    if (ball_x !== 8'(ex) || ball_y !== 7'(ey) || hit !== 1'(eh) ||
        score_l !== 1'(esl) || score_r !== 1'(esr) || playing !== 1'(ep)) begin
      fails++;
      $display("FAIL %s got x=%0d y=%0d hit=%b sl=%b sr=%b play=%b want x=%0d y=%0d hit=%0d sl=%0d sr=%0d play=%0d",
               name, ball_x, ball_y, hit, score_l, score_r, playing,
               ex, ey, eh, esl, esr, ep);
    end
  endtask

  function automatic int pick_pad();
    int p;
    if ($urandom_range(0, 1) == 1) begin
      p = m_y + BS - int'($urandom_range(0, 21));
      if (p < 0) p = 0;
      if (p > 127) p = 127;
    end else begin
      p = int'($urandom_range(0, 127));
    end
    return p;
  endfunction

  typedef struct {
    int n, rst, tick, start, pl, pr;
    int ex, ey, eh, esl, esr, ep;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // n  rst tick start pl pr   x    y  hit sl sr play
    vecs.push_back('{1,   0, 1, 0,  0,   0,  78,  58, 0, 0, 0, 0}); // reset
    vecs.push_back('{40,  1, 1, 0,  0,   0,  78,  58, 0, 0, 0, 0}); // idle ignores ticks
    vecs.push_back('{1,   1, 1, 1,  0,   0,  78,  58, 0, 0, 0, 1}); // start+tick: tick not counted
    vecs.push_back('{29,  1, 1, 0,  0,   0,  78,  58, 0, 0, 0, 1}); // still serving
    vecs.push_back('{1,   1, 1, 0,  0,   0,  78,  58, 0, 0, 0, 1}); // 30th tick enters MOVE
    vecs.push_back('{1,   1, 1, 0,  0,   0,  79,  59, 0, 0, 0, 1}); // first step
    vecs.push_back('{1,   1, 0, 0,  0,   0,  79,  59, 0, 0, 0, 1}); // no tick, hold
    vecs.push_back('{5,   1, 1, 1,  0,   0,  84,  64, 0, 0, 0, 1}); // start ignored
    vecs.push_back('{52,  1, 1, 0,  0,   0, 136, 116, 0, 0, 0, 1}); // bottom row
    vecs.push_back('{1,   1, 1, 0,  0,   0, 137, 115, 0, 0, 0, 1}); // bottom bounce
    vecs.push_back('{11,  1, 1, 0,  0,   0, 148, 104, 0, 0, 0, 1}); // at right face
    vecs.push_back('{1,   1, 1, 0,  0, 100, 147, 103, 1, 0, 0, 1}); // right paddle hit
    vecs.push_back('{1,   1, 0, 0,  0, 100, 147, 103, 0, 0, 0, 1}); // hit lasts one cycle
    vecs.push_back('{103, 1, 1, 0,  0,   0,  44,   0, 0, 0, 0, 1}); // top row
    vecs.push_back('{1,   1, 1, 0,  0,   0,  43,   1, 0, 0, 0, 1}); // top bounce
    vecs.push_back('{35,  1, 1, 0,  0,   0,   8,  36, 0, 0, 0, 1}); // at left face
    vecs.push_back('{1,   1, 1, 0, 60,   0,   7,  37, 0, 0, 0, 1}); // paddle too low: pass
    vecs.push_back('{7,   1, 1, 0,  0,   0,   0,  44, 0, 0, 0, 1}); // left edge
    vecs.push_back('{1,   1, 1, 0,  0,   0,  78,  58, 0, 0, 1, 1}); // ScoreR, recentre
    vecs.push_back('{1,   1, 0, 0,  0,   0,  78,  58, 0, 0, 0, 1}); // pulse gone
    vecs.push_back('{29,  1, 1, 0,  0,   0,  78,  58, 0, 0, 0, 1}); // serve hold
    vecs.push_back('{1,   1, 1, 0,  0,   0,  78,  58, 0, 0, 0, 1}); // enters MOVE
    vecs.push_back('{1,   1, 1, 0,  0,   0,  77,  59, 0, 0, 0, 1}); // toward loser, DY kept

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i].n, vecs[i].rst, vecs[i].tick, vecs[i].start, vecs[i].pl, vecs[i].pr);
      expect_out($sformatf("vec[%0d]", i), vecs[i].ex, vecs[i].ey, vecs[i].eh,
                 vecs[i].esl, vecs[i].esr, vecs[i].ep);
    end

    // Left paddle hit, then a right-side miss scoring for the left player.
    run(69, 1, 1, 0, 0, 0);    expect_out("left_approach", 8, 104, 0, 0, 0, 1);
    run(1, 1, 1, 0, 100, 0);   expect_out("left_hit", 9, 103, 1, 0, 0, 1);
    run(1, 1, 0, 0, 100, 0);   expect_out("left_hit_clear", 9, 103, 0, 0, 0, 1);
    run(103, 1, 1, 0, 0, 0);   expect_out("top_row_2", 112, 0, 0, 0, 0, 1);
    run(1, 1, 1, 0, 0, 0);     expect_out("top_bounce_2", 113, 1, 0, 0, 0, 1);
    run(35, 1, 1, 0, 0, 0);    expect_out("right_face", 148, 36, 0, 0, 0, 1);
    run(8, 1, 1, 0, 0, 0);     expect_out("right_miss_path", 156, 44, 0, 0, 0, 1);
    run(1, 1, 1, 0, 0, 0);     expect_out("score_l", 78, 58, 0, 1, 0, 1);
    run(1, 1, 0, 0, 0, 0);     expect_out("score_l_clear", 78, 58, 0, 0, 0, 1);
    run(30, 1, 1, 0, 0, 0);    expect_out("serve_2", 78, 58, 0, 0, 0, 1);
    run(1, 1, 1, 0, 0, 0);     expect_out("move_right", 79, 59, 0, 0, 0, 1);
    // Reset together with Tick in MOVE.
    run(1, 0, 1, 0, 0, 0);     expect_out("reset_in_move", 78, 58, 0, 0, 0, 0);
    run(3, 1, 1, 0, 0, 0);     expect_out("idle_after_reset", 78, 58, 0, 0, 0, 0);

    // Randomized play against the model.
    run(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      rst     = ($urandom_range(0, 499) != 0);
      tick    = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 7) == 0);
      pad_l_y = 7'(pick_pad());
      pad_r_y = 7'(pick_pad());
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
